// File: rtl/alu_pkg.sv
// Shared ALU definitions: control codes, legality check and arbiter FSM encoding.
// Imported by every block that drives or arbitrates the shared alu32.
package alu_pkg;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_XOR = 3'b011;
  localparam logic [2:0] ALU_SHR = 3'b100;
  localparam logic [2:0] ALU_ILL = 3'b101;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  // 101 is the only code alu32 does not implement.
  function automatic logic gin_illegal(input logic [2:0] gin);
    return (gin == ALU_ILL);
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Bundle of both requester handshakes, the ALU connection and the response bus.
// The slave side is the arbiter; the master side is the requesters plus the ALU.
interface alu_arbiter_if #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
);

  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic [2:0]       req0_gin;
  logic [SHW-1:0]   req0_sham;

  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic [2:0]       req1_gin;
  logic [SHW-1:0]   req1_sham;

  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [2:0]       alu_gin;
  logic [SHW-1:0]   alu_sham;
  logic [WIDTH-1:0] alu_sum;
  logic             alu_zout;
  logic             alu_nout;

  logic             rsp_valid;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_sum;
  logic             rsp_zout;
  logic             rsp_nout;
  logic             rsp_err;

  modport master (
    output req0_valid, req0_a, req0_b, req0_gin, req0_sham,
    output req1_valid, req1_a, req1_b, req1_gin, req1_sham,
    output alu_sum, alu_zout, alu_nout,
    input  req0_ready, req1_ready,
    input  alu_a, alu_b, alu_gin, alu_sham,
    input  rsp_valid, rsp_id, rsp_sum, rsp_zout, rsp_nout, rsp_err
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_gin, req0_sham,
    input  req1_valid, req1_a, req1_b, req1_gin, req1_sham,
    input  alu_sum, alu_zout, alu_nout,
    output req0_ready, req1_ready,
    output alu_a, alu_b, alu_gin, alu_sham,
    output rsp_valid, rsp_id, rsp_sum, rsp_zout, rsp_nout, rsp_err
  );

endinterface

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: combinational one-hot grant plus the last-winner register.
// Requester 0 wins the first tie after reset.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic last_id_r;

  // Grant: a lone requester wins, a tie goes to whoever did not win last.
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last_id_r ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  // Remember the winner of every grant.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_id_r <= 1'b1;
    end else if (gnt != 2'b00) begin
      last_id_r <= gnt[1];
    end else begin
      last_id_r <= last_id_r;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational alu32 between two valid/ready requesters, round robin.
// Operands are registered onto the ALU, the result captured one cycle later and returned tagged.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input logic          clk,
  input logic          reset,
  alu_arbiter_if.slave bus
);

  arb_state_e       state_r;
  arb_state_e       state_s;
  logic             accepting_s;
  logic [1:0]       req_s;
  logic [1:0]       gnt_s;

  logic [WIDTH-1:0] sel_a_s;
  logic [WIDTH-1:0] sel_b_s;
  logic [2:0]       sel_gin_s;
  logic [SHW-1:0]   sel_sham_s;

  logic [WIDTH-1:0] alu_a_r;
  logic [WIDTH-1:0] alu_b_r;
  logic [2:0]       alu_gin_r;
  logic [SHW-1:0]   alu_sham_r;
  logic             op_id_r;
  logic             op_err_r;

  logic             rsp_valid_r;
  logic             rsp_id_r;
  logic [WIDTH-1:0] rsp_sum_r;
  logic             rsp_zout_r;
  logic             rsp_nout_r;
  logic             rsp_err_r;

  // Accepting only in IDLE/RESP, and never while reset is held.
  assign accepting_s = !reset && ((state_r == IDLE) || (state_r == RESP));
  assign req_s       = {bus.req1_valid, bus.req0_valid} & {2{accepting_s}};

  rr_arb2 u_arb (
    .clk   (clk),
    .reset (reset),
    .req   (req_s),
    .gnt   (gnt_s)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next state: a grant starts an operation, EXEC always hands over to RESP.
  always_comb begin
    state_s = IDLE;
    case (state_r)
      IDLE, RESP: begin
        if (gnt_s != 2'b00) begin
          state_s = EXEC;
        end else begin
          state_s = IDLE;
        end
      end
      EXEC:    state_s = RESP;
      default: state_s = IDLE;
    endcase
  end

  // FSM outputs: ready strobes and the granted requester's fields.
  always_comb begin
    bus.req0_ready = gnt_s[0];
    bus.req1_ready = gnt_s[1];
    if (gnt_s[1]) begin
      sel_a_s    = bus.req1_a;
      sel_b_s    = bus.req1_b;
      sel_gin_s  = bus.req1_gin;
      sel_sham_s = bus.req1_sham;
    end else begin
      sel_a_s    = bus.req0_a;
      sel_b_s    = bus.req0_b;
      sel_gin_s  = bus.req0_gin;
      sel_sham_s = bus.req0_sham;
    end
  end

  // Issue registers: load on accept, otherwise hold so the ALU inputs stay quiet.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_a_r    <= {WIDTH{1'b0}};
      alu_b_r    <= {WIDTH{1'b0}};
      alu_gin_r  <= 3'b000;
      alu_sham_r <= {SHW{1'b0}};
      op_id_r    <= 1'b0;
      op_err_r   <= 1'b0;
    end else if (gnt_s != 2'b00) begin
      alu_a_r    <= sel_a_s;
      alu_b_r    <= sel_b_s;
      alu_gin_r  <= sel_gin_s;
      alu_sham_r <= sel_sham_s;
      op_id_r    <= gnt_s[1];
      op_err_r   <= gin_illegal(sel_gin_s);
    end else begin
      alu_a_r    <= alu_a_r;
      alu_b_r    <= alu_b_r;
      alu_gin_r  <= alu_gin_r;
      alu_sham_r <= alu_sham_r;
      op_id_r    <= op_id_r;
      op_err_r   <= op_err_r;
    end
  end

  // Response registers: capture at the end of EXEC; an illegal code returns zeros.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_valid_r <= 1'b0;
      rsp_id_r    <= 1'b0;
      rsp_sum_r   <= {WIDTH{1'b0}};
      rsp_zout_r  <= 1'b0;
      rsp_nout_r  <= 1'b0;
      rsp_err_r   <= 1'b0;
    end else begin
      rsp_valid_r <= (state_r == EXEC);
      if (state_r == EXEC) begin
        rsp_id_r  <= op_id_r;
        rsp_err_r <= op_err_r;
        if (op_err_r) begin
          rsp_sum_r  <= {WIDTH{1'b0}};
          rsp_zout_r <= 1'b0;
          rsp_nout_r <= 1'b0;
        end else begin
          rsp_sum_r  <= bus.alu_sum;
          rsp_zout_r <= bus.alu_zout;
          rsp_nout_r <= bus.alu_nout;
        end
      end else begin
        rsp_id_r   <= rsp_id_r;
        rsp_err_r  <= rsp_err_r;
        rsp_sum_r  <= rsp_sum_r;
        rsp_zout_r <= rsp_zout_r;
        rsp_nout_r <= rsp_nout_r;
      end
    end
  end

  assign bus.alu_a     = alu_a_r;
  assign bus.alu_b     = alu_b_r;
  assign bus.alu_gin   = alu_gin_r;
  assign bus.alu_sham  = alu_sham_r;
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_id    = rsp_id_r;
  assign bus.rsp_sum   = rsp_sum_r;
  assign bus.rsp_zout  = rsp_zout_r;
  assign bus.rsp_nout  = rsp_nout_r;
  assign bus.rsp_err   = rsp_err_r;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: models alu32, predicts responses into a scoreboard
// when an accept is expected, and checks them when rsp_valid pulses.
module tb_alu_arbiter;
  import alu_pkg::*;

  typedef struct {
    logic        id;
    logic [31:0] sum;
    logic        z;
    logic        n;
    logic        err;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  exp_t sb[$];

  alu_arbiter_if #(.WIDTH(32), .SHW(5)) bus ();

  alu_arbiter #(.WIDTH(32), .SHW(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference alu32 behaviour; also used to drive the DUT's ALU inputs.
  function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                        input logic [2:0] gin, input logic [4:0] sh);
    case (gin)
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b010:  return a + b;
      3'b011:  return a ^ b;
      3'b100:  return b >> sh;
      3'b110:  return a - b;
      3'b111:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return 32'hdead_beef;
    endcase
  endfunction

  assign bus.alu_sum  = alu_f(bus.alu_a, bus.alu_b, bus.alu_gin, bus.alu_sham);
  assign bus.alu_zout = (bus.alu_sum == 32'd0);
  assign bus.alu_nout = bus.alu_sum[31];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    tests++;
    assert (got === want) else begin
      fails++;
      $error("FAIL %s: got %0h, expected %0h", tag, got, want);
    end
  endtask

  task automatic set0(input logic v, input logic [31:0] a, input logic [31:0] b,
                      input logic [2:0] gin, input logic [4:0] sh);
    bus.req0_valid = v; bus.req0_a = a; bus.req0_b = b; bus.req0_gin = gin; bus.req0_sham = sh;
  endtask

  task automatic set1(input logic v, input logic [31:0] a, input logic [31:0] b,
                      input logic [2:0] gin, input logic [4:0] sh);
    bus.req1_valid = v; bus.req1_a = a; bus.req1_b = b; bus.req1_gin = gin; bus.req1_sham = sh;
  endtask

  function automatic exp_t mk(input logic id, input logic [31:0] a, input logic [31:0] b,
                              input logic [2:0] gin, input logic [4:0] sh);
    exp_t e;
    e.id  = id;
    e.err = (gin == 3'b101);
    e.sum = e.err ? 32'd0 : alu_f(a, b, gin, sh);
    e.z   = e.err ? 1'b0 : (e.sum == 32'd0);
    e.n   = e.err ? 1'b0 : e.sum[31];
    e.due = cyc + 2;
    return e;
  endfunction

  // One clock; then compare any response against the head of the scoreboard.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (bus.rsp_valid === 1'b1) begin
      tests++;
      assert (sb.size() > 0) else begin
        fails++;
        $error("FAIL rsp_unexpected: got rsp_valid=1 id=%0d, expected no response", bus.rsp_id);
      end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("rsp_latency", cyc, e.due);
        chk("rsp_id", {31'd0, bus.rsp_id}, {31'd0, e.id});
        chk("rsp_sum", bus.rsp_sum, e.sum);
        chk("rsp_zout", {31'd0, bus.rsp_zout}, {31'd0, e.z});
        chk("rsp_nout", {31'd0, bus.rsp_nout}, {31'd0, e.n});
        chk("rsp_err", {31'd0, bus.rsp_err}, {31'd0, e.err});
      end
    end
  endtask

  // Check the ready strobes; on an expected accept, predict its response.
  task automatic issue(input logic e0, input logic e1, input logic push);
    #1;
    chk("req0_ready", {31'd0, bus.req0_ready}, {31'd0, e0});
    chk("req1_ready", {31'd0, bus.req1_ready}, {31'd0, e1});
    if (push && e0) sb.push_back(mk(1'b0, bus.req0_a, bus.req0_b, bus.req0_gin, bus.req0_sham));
    else if (push && e1) sb.push_back(mk(1'b1, bus.req1_a, bus.req1_b, bus.req1_gin, bus.req1_sham));
  endtask

  // A single operation from one requester, followed by its EXEC cycle.
  task automatic single(input logic r, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] gin, input logic [4:0] sh);
    if (r) set1(1'b1, a, b, gin, sh); else set0(1'b1, a, b, gin, sh);
    issue(!r, r, 1'b1);
    tick();
    set0(1'b0, 32'd0, 32'd0, 3'b000, 5'd0);
    set1(1'b0, 32'd0, 32'd0, 3'b000, 5'd0);
    issue(1'b0, 1'b0, 1'b0);
    tick();
  endtask

  task automatic drain();
    for (int k = 0; k < 8 && sb.size() > 0; k++) tick();
    chk("scoreboard_drained", sb.size(), 32'd0);
  endtask

  task automatic chk_reset_state();
    chk("rst_alu_a", bus.alu_a, 32'd0);
    chk("rst_alu_b", bus.alu_b, 32'd0);
    chk("rst_alu_gin", {29'd0, bus.alu_gin}, 32'd0);
    chk("rst_alu_sham", {27'd0, bus.alu_sham}, 32'd0);
    chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("rst_rsp_id", {31'd0, bus.rsp_id}, 32'd0);
    chk("rst_rsp_sum", bus.rsp_sum, 32'd0);
    chk("rst_rsp_zout", {31'd0, bus.rsp_zout}, 32'd0);
    chk("rst_rsp_nout", {31'd0, bus.rsp_nout}, 32'd0);
    chk("rst_rsp_err", {31'd0, bus.rsp_err}, 32'd0);
    chk("rst_req0_ready", {31'd0, bus.req0_ready}, 32'd0);
    chk("rst_req1_ready", {31'd0, bus.req1_ready}, 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    set0(1'b0, 32'd0, 32'd0, 3'b000, 5'd0);
    set1(1'b0, 32'd0, 32'd0, 3'b000, 5'd0);
    repeat (2) @(posedge clk);
    #1;
    set0(1'b1, 32'd5, 32'd7, ALU_ADD, 5'd0);
    set1(1'b1, 32'd1, 32'd2, ALU_OR, 5'd0);
    #1;
    chk_reset_state();
    set0(1'b0, 32'd0, 32'd0, 3'b000, 5'd0);
    set1(1'b0, 32'd0, 32'd0, 3'b000, 5'd0);
    @(negedge clk) reset = 1'b0;
    tick();

    // ADD 5 + 7 from requester 0.
    set0(1'b1, 32'd5, 32'd7, ALU_ADD, 5'd0);
    issue(1'b1, 1'b0, 1'b1);
    tick();
    set0(1'b0, 32'd0, 32'd0, 3'b000, 5'd0);
    chk("exec_alu_gin", {29'd0, bus.alu_gin}, 32'd2);
    chk("exec_alu_a", bus.alu_a, 32'd5);
    chk("exec_alu_b", bus.alu_b, 32'd7);
    issue(1'b0, 1'b0, 1'b0);
    tick();
    drain();

    // Both requesters valid continuously after a fresh reset: 0,1,0,1.
    reset = 1'b1;
    @(negedge clk) reset = 1'b0;
    tick();
    set0(1'b1, 32'hff00, 32'h0f0f, ALU_AND, 5'd0);
    set1(1'b1, 32'd1, 32'd2, ALU_OR, 5'd0);
    for (int k = 0; k < 4; k++) begin
      issue((k % 2) == 0, (k % 2) == 1, 1'b1);
      tick();
      issue(1'b0, 1'b0, 1'b0);
      tick();
    end
    set0(1'b0, 32'd0, 32'd0, 3'b000, 5'd0);
    set1(1'b0, 32'd0, 32'd0, 3'b000, 5'd0);
    drain();

    // SHR from requester 1, SLT from requester 0 accepted in the RESP cycle.
    set1(1'b1, 32'd0, 32'h80, ALU_SHR, 5'd4);
    issue(1'b0, 1'b1, 1'b1);
    tick();
    set1(1'b0, 32'd0, 32'd0, 3'b000, 5'd0);
    issue(1'b0, 1'b0, 1'b0);
    tick();
    set0(1'b1, 32'd3, 32'd9, ALU_SLT, 5'd0);
    issue(1'b1, 1'b0, 1'b1);
    tick();
    set0(1'b0, 32'd0, 32'd0, 3'b000, 5'd0);
    issue(1'b0, 1'b0, 1'b0);
    tick();
    drain();

    // Illegal code, then legal ops with negative and zero results.
    single(1'b0, 32'd1, 32'd1, 3'b101, 5'd0);
    single(1'b0, 32'd3, 32'd9, ALU_SUB, 5'd0);
    single(1'b0, 32'd5, 32'd5, ALU_XOR, 5'd0);
    drain();

    // Reset during EXEC of ADD 2 + 2: dropped, then tie goes to requester 0.
    set0(1'b1, 32'd2, 32'd2, ALU_ADD, 5'd0);
    issue(1'b1, 1'b0, 1'b0);
    tick();
    #1 reset = 1'b1;
    set1(1'b1, 32'd6, 32'd1, ALU_OR, 5'd0);
    #1;
    chk_reset_state();
    tick();
    tick();
    reset = 1'b0;
    issue(1'b1, 1'b0, 1'b1);
    tick();
    set0(1'b0, 32'd0, 32'd0, 3'b000, 5'd0);
    set1(1'b0, 32'd0, 32'd0, 3'b000, 5'd0);
    issue(1'b0, 1'b0, 1'b0);
    tick();
    drain();

    // Requester 1 alone, three times back to back.
    for (int k = 0; k < 3; k++) single(1'b1, k + 1, 10 * k, ALU_ADD, 5'd0);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one combinational alu32 between two requesters (e.g. main datapath and an address/branch unit).
- Round-robin arbitration; each requester uses a valid/ready handshake.
- Registers the granted operands onto the ALU, captures the ALU result one cycle later, and returns it on a shared response bus tagged with the requester id.
- Rejects ALU control codes outside the legal set without using the ALU result.

Parameters:
- WIDTH, 32, operand/result width.
- SHW, 5, shift-amount width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 accepted this cycle.
- req0_a  in  WIDTH  operand a.
- req0_b  in  WIDTH  operand b.
- req0_gin  in  3  ALU control code.
- req0_sham  in  SHW  shift amount.
- req1_valid, req1_ready, req1_a, req1_b, req1_gin, req1_sham: same as requester 0, for requester 1.
- alu_a  out  WIDTH  to ALU a.
- alu_b  out  WIDTH  to ALU b.
- alu_gin  out  3  to ALU gin.
- alu_sham  out  SHW  to ALU sham.
- alu_sum  in  WIDTH  from ALU sum.
- alu_zout  in  1  from ALU zout.
- alu_nout  in  1  from ALU nout.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_id  out  1  requester the response belongs to.
- rsp_sum  out  WIDTH  captured result.
- rsp_zout  out  1  captured zero flag.
- rsp_nout  out  1  captured negative flag.
- rsp_err  out  1  illegal control code.

Behaviour:
- Legal gin codes: 000 AND, 001 OR, 010 ADD, 011 XOR, 100 SHR, 110 SUB, 111 SLT. Code 101 is illegal.
- FSM states: IDLE, EXEC, RESP.
  - IDLE or RESP: if a grant is given -> EXEC; else -> IDLE.
  - EXEC -> RESP unconditionally.
- Accepting states are IDLE and RESP. reqN_ready is combinational: state is accepting AND reqN_valid AND the arbiter picks N. At most one ready is high per cycle.
- Round robin: register last_id, reset value 1, so requester 0 wins the first tie.
  - Both valid: grant goes to !last_id.
  - One valid: that requester is granted.
  - last_id updates on every accept.
- Accept edge (cycle T): alu_a/b/gin/sham, op_id and op_err are registered from the granted requester. op_err = (gin == 101).
- Cycle T+1 (EXEC): alu_* stable; ALU settles combinationally. At the end-of-cycle edge, capture into the rsp registers:
  - rsp_sum, rsp_zout, rsp_nout from alu_sum, alu_zout, alu_nout;
  - rsp_err = op_err; rsp_id = op_id.
  - If op_err = 1: capture rsp_sum = 0, rsp_zout = 0, rsp_nout = 0 instead of the ALU outputs.
- Cycle T+2 (RESP): rsp_valid = 1 for exactly one cycle.
  - Latency: 2 cycles from the accept edge to rsp_valid.
  - Throughput: one operation per 2 cycles (accept in RESP overlaps).
- The rsp_* data registers hold their last value while rsp_valid = 0.
- alu_* hold the last issued operands between operations; no toggling while idle.
- Responses have no backpressure; the requester must sink rsp_valid in the same cycle.
- Requester fields are sampled only at the accept edge; changes while ready is low are ignored.
- Reset (asynchronous, any state, including mid-EXEC):
  - state = IDLE, last_id = 1;
  - alu_a = alu_b = 0, alu_gin = 000, alu_sham = 0;
  - rsp_valid = 0, rsp_id = 0, rsp_sum = 0, rsp_zout = 0, rsp_nout = 0, rsp_err = 0;
  - any in-flight operation is dropped with no response.
- While reset is high, both reqN_ready are 0.

Decomposition:
- Shared package alu_pkg:
  - gin code constants: ALU_AND, ALU_OR, ALU_ADD, ALU_XOR, ALU_SHR, ALU_SUB, ALU_SLT;
  - illegal-code check function;
  - FSM state encoding (IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2).
- One sub-module: rr_arb2. Combinational grant from two valids and last_id, plus the last_id register. Reused by later shared-resource blocks.

Test Plan:
- Reset, then req0 only: ADD a = 5, b = 7 -> req0_ready high in the accept cycle; alu_gin = 010 next cycle; rsp_valid 2 cycles after accept with rsp_id = 0, rsp_sum = 12, rsp_zout = 0, rsp_err = 0.
- Both valid continuously: req0 AND ff00/0f0f, req1 OR 1/2 -> grants alternate 0, 1, 0, 1 starting with 0; responses 0x0f00 (id 0) and 3 (id 1); one accept every 2 cycles.
- req1 SHR b = 0x80, sham = 4 -> rsp_sum = 0x8, rsp_id = 1. Same response cycle, req0 presents SLT a = 3, b = 9 -> accepted in RESP; its response appears 2 cycles later with rsp_sum = 1.
- req0 gin = 101, a = 1, b = 1 -> rsp_err = 1, rsp_sum = 0, rsp_zout = 0, rsp_nout = 0; the next legal op is unaffected.
- Assert reset during EXEC of ADD 2 + 2 -> no rsp_valid ever for it; all outputs at reset values; the next op after release is granted to requester 0 on a tie.
- Only req1 valid 3 times back-to-back -> req1 granted each time; req0_ready stays 0.
